// File: rtl/iomem_arbiter.sv
// iomem region decoder/sequencer: claims addr[31:24]==REGION accesses, routes them to one
// of NSLAVES slave ports and returns ready/rdata, with a timeout watchdog for dead slaves.
module iomem_arbiter #(
    parameter int          NSLAVES  = 4,
    parameter logic [7:0]  REGION   = 8'h03,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   m_valid,
    output logic                   m_ready,
    input  logic [3:0]             m_wstrb,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    output logic [31:0]            m_rdata,
    output logic [NSLAVES-1:0]     s_valid,
    output logic [3:0]             s_wstrb,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    input  logic [NSLAVES-1:0]     s_ready,
    input  logic [32*NSLAVES-1:0]  s_rdata,
    output logic                   err_irq,
    output logic [31:0]            err_addr,
    output logic [7:0]             err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT) - 32'd1;

    state_t               state_q, state_d;
    logic                 m_ready_q, m_ready_d;
    logic [31:0]          m_rdata_q, m_rdata_d;
    logic [NSLAVES-1:0]   s_valid_q, s_valid_d;
    logic [3:0]           s_wstrb_q, s_wstrb_d;
    logic [31:0]          s_addr_q, s_addr_d;
    logic [31:0]          s_wdata_q, s_wdata_d;
    logic [3:0]           idx_q, idx_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 err_irq_q, err_irq_d;
    logic [31:0]          err_addr_q, err_addr_d;
    logic [7:0]           err_count_q, err_count_d;

    logic                 idx_ok_s;
    logic [NSLAVES-1:0]   onehot_s;
    logic                 sel_ready_s;
    logic [31:0]          sel_rdata_s;
    logic                 error_s;

    // Decode the incoming index and mux the currently selected slave's response.
    always_comb begin
        idx_ok_s    = ({1'b0, m_addr[19:16]} < 5'(NSLAVES));
        onehot_s    = '0;
        sel_ready_s = 1'b0;
        sel_rdata_s = 32'd0;
        for (int i = 0; i < NSLAVES; i++) begin
            onehot_s[i] = (m_addr[19:16] == 4'(i));
            if (idx_q == 4'(i)) begin
                sel_ready_s = s_ready[i];
                sel_rdata_s = s_rdata[32*i +: 32];
            end else begin
                sel_ready_s = sel_ready_s;
            end
        end
    end

    // Next-state and output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        m_ready_d   = 1'b0;
        m_rdata_d   = m_rdata_q;
        s_valid_d   = s_valid_q;
        s_wstrb_d   = s_wstrb_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_irq_d   = 1'b0;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        error_s     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 32'd0;
                if (m_valid && !m_ready_q && (m_addr[31:24] == REGION)) begin
                    s_addr_d  = m_addr;
                    s_wstrb_d = m_wstrb;
                    s_wdata_d = m_wdata;
                    idx_d     = m_addr[19:16];
                    if (idx_ok_s) begin
                        s_valid_d = onehot_s;
                        state_d   = ACCESS;
                    end else begin
                        error_s    = 1'b1;
                        err_addr_d = m_addr;
                        state_d    = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // A ready arriving on the expiry cycle still counts as normal completion.
                if (sel_ready_s) begin
                    m_rdata_d = sel_rdata_s;
                    m_ready_d = 1'b1;
                    s_valid_d = '0;
                    state_d   = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST)) begin
                    s_valid_d  = '0;
                    error_s    = 1'b1;
                    err_addr_d = s_addr_q;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP: begin
                cnt_d   = 32'd0;
                state_d = IDLE;
            end
            default: begin
                s_valid_d = '0;
                cnt_d     = 32'd0;
                state_d   = IDLE;
            end
        endcase

        if (error_s) begin
            m_rdata_d   = ERR_DATA;
            m_ready_d   = 1'b1;
            err_irq_d   = 1'b1;
            err_count_d = (err_count_q == 8'hFF) ? 8'hFF : (err_count_q + 8'd1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            m_ready_q   <= 1'b0;
            m_rdata_q   <= 32'd0;
            s_valid_q   <= '0;
            s_wstrb_q   <= 4'd0;
            s_addr_q    <= 32'd0;
            s_wdata_q   <= 32'd0;
            idx_q       <= 4'd0;
            cnt_q       <= 32'd0;
            err_irq_q   <= 1'b0;
            err_addr_q  <= 32'd0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            m_ready_q   <= m_ready_d;
            m_rdata_q   <= m_rdata_d;
            s_valid_q   <= s_valid_d;
            s_wstrb_q   <= s_wstrb_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_irq_q   <= err_irq_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign m_ready   = m_ready_q;
    assign m_rdata   = m_rdata_q;
    assign s_valid   = s_valid_q;
    assign s_wstrb   = s_wstrb_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign err_irq   = err_irq_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed, table-driven bench for iomem_arbiter (NSLAVES=4, TIMEOUT=255).
module tb_iomem_arbiter;

    localparam int NS = 4;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           m_valid = 1'b0;
    logic           m_ready;
    logic [3:0]     m_wstrb = 4'd0;
    logic [31:0]    m_addr = 32'd0;
    logic [31:0]    m_wdata = 32'd0;
    logic [31:0]    m_rdata;
    logic [NS-1:0]  s_valid;
    logic [3:0]     s_wstrb;
    logic [31:0]    s_addr;
    logic [31:0]    s_wdata;
    logic [NS-1:0]  s_ready = '0;
    logic [32*NS-1:0] s_rdata = '0;
    logic           err_irq;
    logic [31:0]    err_addr;
    logic [7:0]     err_count;

    int checks = 0;
    int errors = 0;
    int err_model = 0;
    logic [31:0] err_addr_model = 32'd0;

    always #5 clk = ~clk;

    iomem_arbiter #(
        .NSLAVES (NS),
        .REGION  (8'h03),
        .TIMEOUT (255),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .err_irq(err_irq), .err_addr(err_addr), .err_count(err_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          rdelay;     // s_valid cycles before ready; -1 = never
        logic [31:0] srdata;
        logic [3:0]  junk;       // unselected s_ready bits driven while waiting
        bit          drop;       // drop m_valid right after acceptance
        int          exp_lat;    // cycles from acceptance edge to m_ready; -1 = none
        int          exp_sv;     // cycles s_valid is high
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int lat;
        int sv;
        logic [31:0] rd;
        logic irq;
        logic [3:0] idx;
        logic [3:0] onehot;
        idx    = v.addr[19:16];
        onehot = (idx < 4'(NS)) ? (4'b0001 << idx) : 4'b0000;
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = v.addr;
        m_wstrb = v.wstrb;
        m_wdata = v.wdata;
        s_ready = '0;
        for (int i = 0; i < NS; i++)
            s_rdata[32*i +: 32] = (4'(i) == idx) ? v.srdata : ~v.srdata;
        lat = -1;
        sv  = 0;
        rd  = 32'd0;
        irq = 1'b0;
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            @(negedge clk);
            if (v.drop) m_valid = 1'b0;
            if (s_valid != 4'b0000) begin
                sv++;
                chk("s_valid_onehot", 32'(s_valid), 32'(onehot));
                chk("s_addr_stable", s_addr, v.addr);
                chk("s_wdata_stable", s_wdata, v.wdata);
                chk("s_wstrb_stable", 32'(s_wstrb), 32'(v.wstrb));
            end
            if (m_ready) begin
                lat = k;
                rd  = m_rdata;
                irq = err_irq;
                m_valid = 1'b0;
            end
            if (s_valid != 4'b0000)
                s_ready = (v.rdelay >= 0 && sv == v.rdelay + 1) ? onehot : v.junk;
            else
                s_ready = '0;
        end
        m_valid = 1'b0;
        s_ready = '0;
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("s_valid_cycles", 32'(sv), 32'(v.exp_sv));
        if (v.exp_lat > 0) begin
            chk("m_rdata", rd, v.exp_rdata);
            chk("err_irq", 32'(irq), 32'(v.exp_err));
        end
        if (v.exp_err) begin
            err_model      = (err_model == 255) ? 255 : err_model + 1;
            err_addr_model = v.addr;
        end
        @(negedge clk);
        chk("m_ready_single_pulse", 32'(m_ready), 32'd0);
        chk("err_irq_single_pulse", 32'(err_irq), 32'd0);
        chk("s_valid_idle", 32'(s_valid), 32'd0);
        chk("err_count", 32'(err_count), 32'(err_model));
        chk("err_addr", err_addr, err_addr_model);
    endtask

    initial begin
        vecs[0] = '{32'h0301_0004, 4'b0000, 32'h0000_0000,   0, 32'h1234_5678, 4'b0000, 1'b0,   2,   1, 32'h1234_5678, 1'b0};
        vecs[1] = '{32'h0300_0010, 4'b0011, 32'hAABB_CCDD,   5, 32'h0000_0000, 4'b0000, 1'b0,   7,   6, 32'h0000_0000, 1'b0};
        vecs[2] = '{32'h0302_0000, 4'b0000, 32'h0000_0000,  -1, 32'h5555_0000, 4'b0000, 1'b0, 256, 255, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{32'h0307_0000, 4'b1111, 32'h1111_2222,  -1, 32'h0000_0000, 4'b0000, 1'b0,   1,   0, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{32'h0200_0000, 4'b0000, 32'h0000_0000,  -1, 32'h0000_0000, 4'b0000, 1'b0,  -1,   0, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'h0303_0008, 4'b0000, 32'h0000_0000, 254, 32'hCAFE_F00D, 4'b0000, 1'b0, 256, 255, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{32'h0301_0000, 4'b0000, 32'h0000_0000,   2, 32'h0BAD_F00D, 4'b1000, 1'b0,   4,   3, 32'h0BAD_F00D, 1'b0};
        vecs[7] = '{32'h0303_0000, 4'b1111, 32'h0102_0304,   3, 32'h7777_8888, 4'b0000, 1'b1,   5,   4, 32'h7777_8888, 1'b0};
        vecs[8] = '{32'h030F_00FF, 4'b0000, 32'h0000_0000,  -1, 32'h0000_0000, 4'b0000, 1'b0,   1,   0, 32'hDEAD_BEEF, 1'b1};
        vecs[9] = '{32'h0401_0000, 4'b0000, 32'h0000_0000,  -1, 32'h0000_0000, 4'b0000, 1'b0,  -1,   0, 32'h0000_0000, 1'b0};

        // Reset values.
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        chk("rst_s_wstrb", 32'(s_wstrb), 32'd0);
        chk("rst_err_irq", 32'(err_irq), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) run(vecs[i]);

        // Reset while an access to a silent slave is in flight.
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h0302_0000;
        m_wstrb = 4'b0000;
        repeat (4) @(negedge clk);
        chk("mid_access_s_valid", 32'(s_valid), 32'h4);
        resetn  = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        chk("reset_abort_s_valid", 32'(s_valid), 32'd0);
        chk("reset_abort_m_ready", 32'(m_ready), 32'd0);
        chk("reset_abort_err_count", 32'(err_count), 32'd0);
        err_model      = 0;
        err_addr_model = 32'd0;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_abort_no_resp", 32'(m_ready), 32'd0);
        end

        // Error counter saturation.
        for (int i = 0; i < 300; i++) run(vecs[3]);
        chk("err_count_saturated", 32'(err_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
